// File: rtl/mccu_pkg.sv
// rtl/mccu_pkg.sv - shared constants and sum-width helper for the contention quota unit
package mccu_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_WEIGHTS_WIDTH = 7;
  localparam int DEFAULT_N_CORES       = 1;
  localparam int DEFAULT_CORE_EVENTS   = 1;

  // Wide enough that every event line firing at full weight cannot overflow.
  function automatic int mccu_sum_width(input int weights_width, input int core_events);
    return weights_width + $clog2(core_events + 1);
  endfunction

endpackage

// File: rtl/mccu_weight_sum.sv
// rtl/mccu_weight_sum.sv - registered weighted sum of one core's active event lines
module mccu_weight_sum
  import mccu_pkg::*;
#(
  parameter int WEIGHTS_WIDTH = DEFAULT_WEIGHTS_WIDTH,
  parameter int CORE_EVENTS   = DEFAULT_CORE_EVENTS,
  parameter int SUM_WIDTH     = mccu_sum_width(WEIGHTS_WIDTH, CORE_EVENTS)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [CORE_EVENTS-1:0]   events_i,
  input  logic [WEIGHTS_WIDTH-1:0] weights_i [CORE_EVENTS],
  output logic [SUM_WIDTH-1:0]     sum_o
);

  logic [SUM_WIDTH-1:0] sum_d;
  logic [SUM_WIDTH-1:0] sum_q;

  always_comb begin
    sum_d = '0;
    for (int e = 0; e < CORE_EVENTS; e++) begin
      if (events_i[e]) begin
        sum_d = sum_d + SUM_WIDTH'(weights_i[e]);
      end
    end
  end

  // Captured regardless of enable so events seen while disabled are not lost.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mccu_quota_unit.sv
// rtl/mccu_quota_unit.sv - per-core contention quota registers with sticky exhaustion interrupt
module mccu_quota_unit
  import mccu_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int WEIGHTS_WIDTH = DEFAULT_WEIGHTS_WIDTH,
  parameter int N_CORES       = DEFAULT_N_CORES,
  parameter int CORE_EVENTS   = DEFAULT_CORE_EVENTS
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic [CORE_EVENTS-1:0]   events_i [N_CORES],
  input  logic [DATA_WIDTH-1:0]    quota_i [N_CORES],
  input  logic [N_CORES-1:0]       update_quota_i,
  input  logic [WEIGHTS_WIDTH-1:0] events_weights_i [N_CORES][CORE_EVENTS],
  output logic [DATA_WIDTH-1:0]    quota_o [N_CORES],
  output logic [N_CORES-1:0]       interruption_quota_o
);

  localparam int SUM_WIDTH = mccu_sum_width(WEIGHTS_WIDTH, CORE_EVENTS);
  localparam int EXT_WIDTH = (SUM_WIDTH > DATA_WIDTH) ? SUM_WIDTH : DATA_WIDTH;

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    logic [SUM_WIDTH-1:0]  sum_q;
    logic [EXT_WIDTH-1:0]  sum_ext;
    logic [EXT_WIDTH-1:0]  quota_ext;
    logic [DATA_WIDTH-1:0] quota_q;
    logic                  intr_q;
    logic                  exhausted;

    mccu_weight_sum #(
      .WEIGHTS_WIDTH (WEIGHTS_WIDTH),
      .CORE_EVENTS   (CORE_EVENTS),
      .SUM_WIDTH     (SUM_WIDTH)
    ) u_weight_sum (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .events_i  (events_i[c]),
      .weights_i (events_weights_i[c]),
      .sum_o     (sum_q)
    );

    assign sum_ext   = EXT_WIDTH'(sum_q);
    assign quota_ext = EXT_WIDTH'(quota_q);
    // A zero sum never counts as exhaustion, even with the quota already at 0.
    assign exhausted = (sum_ext >= quota_ext) && (sum_q != '0);

    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        quota_q <= '0;
        intr_q  <= 1'b0;
      end else if (update_quota_i[c]) begin
        quota_q <= quota_i[c];
        intr_q  <= 1'b0;
      end else if (enable_i) begin
        if (exhausted) begin
          quota_q <= '0;
          intr_q  <= 1'b1;
        end else begin
          quota_q <= DATA_WIDTH'(quota_ext - sum_ext);
        end
      end
    end

    assign quota_o[c]              = quota_q;
    assign interruption_quota_o[c] = intr_q;
  end

endmodule

// File: tb/tb_mccu_quota_unit.sv
// tb/tb_mccu_quota_unit.sv - directed self-checking bench for mccu_quota_unit
module tb_mccu_quota_unit;

  localparam int DW = 32;
  localparam int WW = 7;
  localparam int NC = 2;
  localparam int CE = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic [CE-1:0] events [NC];
  logic [DW-1:0] quota_in [NC];
  logic [NC-1:0] update;
  logic [WW-1:0] weights [NC][CE];
  logic [DW-1:0] quota_out [NC];
  logic [NC-1:0] intr;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mccu_quota_unit #(
    .DATA_WIDTH    (DW),
    .WEIGHTS_WIDTH (WW),
    .N_CORES       (NC),
    .CORE_EVENTS   (CE)
  ) dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .enable_i             (enable),
    .events_i             (events),
    .quota_i              (quota_in),
    .update_quota_i       (update),
    .events_weights_i     (weights),
    .quota_o              (quota_out),
    .interruption_quota_o (intr)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_core(input string tag, input int c, input logic [DW-1:0] q, input logic irq);
    check_eq({tag, "_quota"}, 64'(quota_out[c]), 64'(q));
    check_eq({tag, "_intr"}, 64'(intr[c]), 64'(irq));
  endtask

  initial begin
    rstn   = 1'b0;
    enable = 1'b0;
    update = '0;
    for (int c = 0; c < NC; c++) begin
      events[c]   = '0;
      quota_in[c] = '0;
      for (int e = 0; e < CE; e++) weights[c][e] = '0;
    end
    tick();
    tick();
    check_core("reset_c0", 0, 0, 1'b0);
    check_core("reset_c1", 1, 0, 1'b0);

    // Quota loads
    rstn = 1'b1;
    enable = 1'b1;
    quota_in[0] = 150; update[0] = 1'b1;
    tick();
    check_core("load150", 0, 150, 1'b0);
    quota_in[0] = 200;
    tick();
    check_core("load200", 0, 200, 1'b0);
    update[0] = 1'b0;

    // Events while disabled are not consumed
    enable = 1'b0;
    weights[0][0] = 10;
    events[0] = 4'b0001;
    tick(); tick(); tick();
    check_core("disabled_hold", 0, 200, 1'b0);

    // Enable: captured sum consumed; dropping the event still costs one more pipelined sum
    enable = 1'b1;
    tick();
    check_core("enable_first", 0, 190, 1'b0);
    events[0] = 4'b0000;
    tick();
    check_core("pipelined", 0, 180, 1'b0);
    tick();
    tick();
    check_core("idle_hold", 0, 180, 1'b0);

    // Reset mid-operation then saturate at zero
    rstn = 1'b0;
    tick();
    check_core("midreset", 0, 0, 1'b0);
    rstn = 1'b1;
    events[0] = 4'b0001;
    tick();
    check_core("sat_edge1", 0, 0, 1'b0);
    tick();
    check_core("sat_edge2", 0, 0, 1'b1);
    tick();
    check_core("sat_sticky", 0, 0, 1'b1);
    quota_in[0] = 50; update[0] = 1'b1;
    tick();
    check_core("reload50", 0, 50, 1'b0);
    update[0] = 1'b0;
    tick();
    check_core("after50", 0, 40, 1'b0);

    // Non-exact exhaustion
    quota_in[0] = 25; update[0] = 1'b1;
    tick();
    check_core("load25", 0, 25, 1'b0);
    update[0] = 1'b0;
    tick();
    check_core("q25_a", 0, 15, 1'b0);
    tick();
    check_core("q25_b", 0, 5, 1'b0);
    tick();
    check_core("q25_c", 0, 0, 1'b1);

    // Exact-match exhaustion
    quota_in[0] = 20; update[0] = 1'b1;
    tick();
    check_core("load20", 0, 20, 1'b0);
    update[0] = 1'b0;
    tick();
    check_core("q20_a", 0, 10, 1'b0);
    tick();
    check_core("q20_exact", 0, 0, 1'b1);

    // Zero weight at quota 0 must not raise the interrupt
    weights[0][0] = 0;
    quota_in[0] = 0; update[0] = 1'b1;
    tick();
    check_core("load0", 0, 0, 1'b0);
    update[0] = 1'b0;
    tick();
    tick();
    check_core("zero_weight", 0, 0, 1'b0);

    // Two cores, four weighted events each
    for (int e = 0; e < CE; e++) begin
      weights[0][e] = WW'(e + 1);
      weights[1][e] = WW'(e + 5);
    end
    events[0] = 4'hF;
    events[1] = 4'hF;
    quota_in[0] = 100; quota_in[1] = 100; update = 2'b11;
    tick();
    check_core("mc_load_c0", 0, 100, 1'b0);
    check_core("mc_load_c1", 1, 100, 1'b0);
    update = 2'b00;
    tick();
    check_core("mc1_c0", 0, 90, 1'b0);
    check_core("mc1_c1", 1, 74, 1'b0);
    tick();
    check_core("mc2_c0", 0, 80, 1'b0);
    check_core("mc2_c1", 1, 48, 1'b0);
    update = 2'b10;
    tick();
    check_core("mc_upd1_c0", 0, 70, 1'b0);
    check_core("mc_upd1_c1", 1, 100, 1'b0);
    update = 2'b00;
    tick();
    check_core("mc3_c0", 0, 60, 1'b0);
    check_core("mc3_c1", 1, 74, 1'b0);
    tick();
    tick();
    tick();
    check_core("mc6_c0", 0, 30, 1'b0);
    check_core("mc6_c1", 1, 0, 1'b1);

    // Interrupt survives enable dropping; quota holds
    enable = 1'b0;
    tick();
    tick();
    check_core("dis_c0", 0, 30, 1'b0);
    check_core("dis_c1", 1, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
